// File: rtl/isqrt_sum_pipe_pkg.sv
// Package for the isqrt_sum_pipe block: default parameters and the width /
// tree-shape helpers shared by the top level and the bench-facing ports.
package isqrt_sum_pkg;

  localparam int N_CH_DEF         = 3;
  localparam int W_DEF            = 32;
  localparam int ISQRT_STAGES_DEF = 4;

  // Number of registered adder-tree levels needed to reduce n terms to one.
  function automatic int tree_levels(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  // Result width: one root of w/2 bits, plus one carry bit per tree level.
  function automatic int res_width(input int w, input int n);
    return (w / 2) + tree_levels(n);
  endfunction

  // Number of live terms after l tree levels, starting from n leaves.
  // Pairs are summed and an odd leftover passes through, so each level
  // leaves ceil(previous/2) terms.
  function automatic int tree_count(input int n, input int l);
    int c;
    c = n;
    for (int i = 0; i < l; i++) begin
      c = (c + 1) / 2;
    end
    return c;
  endfunction

endpackage

// File: rtl/isqrt_sum_pipe_isqrt_pipe.sv
// isqrt_pipe: pipelined digit-by-digit restoring integer square root.
// Produces y = floor(sqrt(x)) after ISQRT_STAGES cycles. Each stage resolves
// (W/2)/ISQRT_STAGES root bits, MSB first. Data registers load only when the
// valid entering their stage is high, so idle cycles cause no datapath toggling
// and X on x while x_vld=0 never reaches the registers.
module isqrt_pipe #(
  parameter int W            = 32,
  parameter int ISQRT_STAGES = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           x_vld,
  input  logic [W-1:0]   x,
  output logic           y_vld,
  output logic [W/2-1:0] y
);

  localparam int H   = W / 2;              // root bits
  localparam int BPS = H / ISQRT_STAGES;   // root bits per stage
  localparam int RMW = H + 2;              // remainder never exceeds 2*root+... < 2^(H+2)

  if ((W % 2) != 0 || W < 2) begin : g_bad_w
    $error("isqrt_pipe: W must be even and at least 2");
  end
  if (ISQRT_STAGES < 1 || (H % ISQRT_STAGES) != 0) begin : g_bad_stages
    $error("isqrt_pipe: (W/2) must be a multiple of ISQRT_STAGES");
  end

  logic [ISQRT_STAGES-1:0] vld_q;
  logic [ISQRT_STAGES-1:0] en;
  logic [RMW-1:0]          rem_q  [ISQRT_STAGES];
  logic [RMW-1:0]          rem_d  [ISQRT_STAGES];
  logic [H-1:0]            root_q [ISQRT_STAGES];
  logic [H-1:0]            root_d [ISQRT_STAGES];
  logic [W-1:0]            xs_q   [ISQRT_STAGES];
  logic [W-1:0]            xs_d   [ISQRT_STAGES];

  // Load enable of each stage is the valid entering that stage.
  always_comb begin
    en    = vld_q << 1;
    en[0] = x_vld;
  end

  // Per-stage root recurrence: bring down two radicand bits, try root*4+1,
  // subtract and set the root bit when it fits, otherwise keep the remainder.
  always_comb begin
    logic [RMW-1:0] rem;
    logic [H-1:0]   root;
    logic [W-1:0]   xs;
    logic [RMW-1:0] trial;
    rem   = '0;
    root  = '0;
    xs    = '0;
    trial = '0;
    for (int s = 0; s < ISQRT_STAGES; s++) begin
      if (s == 0) begin
        rem  = '0;
        root = '0;
        xs   = x;
      end else begin
        rem  = rem_q[s-1];
        root = root_q[s-1];
        xs   = xs_q[s-1];
      end
      for (int j = 0; j < BPS; j++) begin
        rem   = {rem[H-1:0], xs[W-1:W-2]};
        xs    = xs << 2;
        trial = {root, 2'b01};
        if (rem >= trial) begin
          rem  = rem - trial;
          root = (root << 1) | H'(1);
        end else begin
          root = root << 1;
        end
      end
      rem_d[s]  = rem;
      root_d[s] = root;
      xs_d[s]   = xs;
    end
  end

  // Valid chain: one flop per stage, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= en;
    end
  end

  // Remainder and remaining radicand bits: load-gated, not reset.
  always_ff @(posedge clk) begin
    for (int s = 0; s < ISQRT_STAGES; s++) begin
      if (en[s]) begin
        rem_q[s] <= rem_d[s];
        xs_q[s]  <= xs_d[s];
      end
    end
  end

  // Partial roots: load-gated; reset so the final root reads 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < ISQRT_STAGES; s++) begin
        root_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < ISQRT_STAGES; s++) begin
        if (en[s]) begin
          root_q[s] <= root_d[s];
        end
      end
    end
  end

  assign y_vld = vld_q[ISQRT_STAGES-1];
  assign y     = root_q[ISQRT_STAGES-1];

endmodule

// File: rtl/isqrt_sum_pipe.sv
// isqrt_sum_pipe: res = sum over channels of floor(sqrt(x_i)).
// N_CH parallel isqrt_pipe instances feed a registered pairwise adder tree.
// Latency ISQRT_STAGES + clog2(N_CH), plus one when ISQRT_SUM_PIPE_OUT_REG_EN
// is defined (adds a valid-gated, reset-to-0 output register).
//
// Valid semantics: arg_vld qualifies args for exactly the cycle it is high;
// there is no ready, the pipe accepts every cycle and never stalls. res_vld
// is high for one cycle per accepted vector, L cycles after its arg_vld, and
// res holds its last value while res_vld is low.
module isqrt_sum_pipe
  import isqrt_sum_pkg::*;
#(
  parameter int N_CH         = N_CH_DEF,
  parameter int W            = W_DEF,
  parameter int ISQRT_STAGES = ISQRT_STAGES_DEF,
  localparam int RW          = res_width(W, N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arg_vld,
  input  logic [N_CH*W-1:0] args,
  output logic              res_vld,
  output logic [RW-1:0]     res
);

  localparam int H   = W / 2;
  localparam int LVL = tree_levels(N_CH);

  if (N_CH < 1) begin : g_bad_n
    $error("isqrt_sum_pipe: N_CH must be at least 1");
  end

  logic [N_CH-1:0] y_vld;
  logic [H-1:0]    y [N_CH];

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    isqrt_pipe #(
      .W            (W),
      .ISQRT_STAGES (ISQRT_STAGES)
    ) u_isqrt (
      .clk   (clk),
      .rst   (rst),
      .x_vld (arg_vld),
      .x     (args[ch*W +: W]),
      .y_vld (y_vld[ch]),
      .y     (y[ch])
    );
  end

  // Tree storage: level 0 is the combinational root outputs, levels 1..LVL
  // are registers. term_q[0] exists only to keep the indexing uniform and is
  // held at zero.
  logic [RW-1:0] cur    [LVL+1][N_CH];
  logic [RW-1:0] term_d [LVL+1][N_CH];
  logic [RW-1:0] term_q [LVL+1][N_CH];
  logic [LVL:0]  vld_q;
  logic [LVL:0]  lv;
  logic          tail_vld;
  logic [RW-1:0] tail;

  // Stage valids: all channels run in lock-step, level 0 valid is their AND.
  always_comb begin
    lv    = vld_q;
    lv[0] = &y_vld;
  end

  // Current terms of every level, roots zero-extended to the result width.
  always_comb begin
    cur = term_q;
    for (int k = 0; k < N_CH; k++) begin
      cur[0][k] = RW'(y[k]);
    end
  end

  // Next terms: adjacent pairs summed, an odd leftover passed through so
  // every term stays cycle-aligned. RW bits hold the full sum, no truncation.
  always_comb begin
    int cnt;
    int pcnt;
    term_d = '{default: '0};
    cnt    = 0;
    pcnt   = 0;
    for (int l = 1; l <= LVL; l++) begin
      cnt  = tree_count(N_CH, l);
      pcnt = tree_count(N_CH, l - 1);
      for (int k = 0; k < cnt; k++) begin
        if ((2 * k + 1) < pcnt) begin
          term_d[l][k] = cur[l-1][2*k] + cur[l-1][2*k+1];
        end else begin
          term_d[l][k] = cur[l-1][2*k];
        end
      end
    end
  end

  // Tree valid chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q    <= lv << 1;
      vld_q[0] <= 1'b0;
    end
  end

  // Tree data: each level loads only when the valid entering it is high.
  // Reset so the final level (which may drive res directly) starts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      term_q <= '{default: '0};
    end else begin
      for (int l = 1; l <= LVL; l++) begin
        if (lv[l-1]) begin
          term_q[l] <= term_d[l];
        end
      end
    end
  end

  assign tail_vld = lv[LVL];
  assign tail     = cur[LVL][0];

`ifdef ISQRT_SUM_PIPE_OUT_REG_EN
  // Optional output register: valid-gated, reset to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_vld <= 1'b0;
      res     <= '0;
    end else begin
      res_vld <= tail_vld;
      if (tail_vld) begin
        res <= tail;
      end
    end
  end
`else
  assign res_vld = tail_vld;
  assign res     = tail;
`endif

endmodule

// File: tb/tb_isqrt_sum_pipe.sv
// Testbench for isqrt_sum_pipe: default 3x32-bit configuration plus a
// 5x16-bit/2-stage instance and a single-channel instance.
module tb_isqrt_sum_pipe;

`ifdef ISQRT_SUM_PIPE_OUT_REG_EN
  localparam int XTRA = 1;
`else
  localparam int XTRA = 0;
`endif
  localparam int L  = 4 + 2 + XTRA;   // main: stages 4, tree levels 2
  localparam int L5 = 2 + 3 + XTRA;   // 5 channels, 2 stages, 3 levels
  localparam int L1 = 4 + XTRA;       // 1 channel, no tree

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        arg_vld;
  logic [95:0] args;
  logic        res_vld;
  logic [17:0] res;

  logic        a5_vld;
  logic [79:0] a5;
  logic        r5_vld;
  logic [10:0] r5;

  logic        a1_vld;
  logic [31:0] a1;
  logic        r1_vld;
  logic [15:0] r1;

  isqrt_sum_pipe #(.N_CH(3), .W(32), .ISQRT_STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .args(args),
    .res_vld(res_vld), .res(res)
  );

  isqrt_sum_pipe #(.N_CH(5), .W(16), .ISQRT_STAGES(2)) u_dut5 (
    .clk(clk), .rst(rst), .arg_vld(a5_vld), .args(a5),
    .res_vld(r5_vld), .res(r5)
  );

  isqrt_sum_pipe #(.N_CH(1), .W(32), .ISQRT_STAGES(4)) u_dut1 (
    .clk(clk), .rst(rst), .arg_vld(a1_vld), .args(a1),
    .res_vld(r1_vld), .res(r1)
  );

  // ---------------- scoreboard state ----------------
  logic [17:0] exp_q[$];
  int          cyc_q[$];
  logic [10:0] exp5_q[$];
  int          cyc5_q[$];
  logic [15:0] exp1_q[$];
  int          cyc1_q[$];
  logic [17:0] last_exp;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [95:0] v3(input logic [31:0] c2, input logic [31:0] c1,
                                     input logic [31:0] c0);
    return {c2, c1, c0};
  endfunction

  task automatic send(input logic [95:0] v, input logic [17:0] e);
    @(posedge clk);
    #1;
    arg_vld = 1'b1;
    args    = v;
    exp_q.push_back(e);
    cyc_q.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      arg_vld = 1'b0;
      args    = 'x;
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [17:0] e;
    int          c;
    if (rst) begin
      exp_q.delete();
      cyc_q.delete();
      last_exp = '0;
    end else if (res_vld) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL main_vld: res_vld=1 res=%0d with no result pending (t=%0t)", res, $time);
      end else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("main_res", 64'(res), 64'(e));
        check("main_latency", 64'(cyc), 64'(c + L));
        last_exp = e;
      end
    end else begin
      check("main_hold", 64'(res), 64'(last_exp));
    end
  end

  always @(negedge clk) begin
    logic [10:0] e;
    int          c;
    if (rst) begin
      exp5_q.delete();
      cyc5_q.delete();
    end else if (r5_vld) begin
      if (exp5_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL n5_vld: res_vld=1 res=%0d with no result pending (t=%0t)", r5, $time);
      end else begin
        e = exp5_q.pop_front();
        c = cyc5_q.pop_front();
        check("n5_res", 64'(r5), 64'(e));
        check("n5_latency", 64'(cyc), 64'(c + L5));
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] e;
    int          c;
    if (rst) begin
      exp1_q.delete();
      cyc1_q.delete();
    end else if (r1_vld) begin
      if (exp1_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL n1_vld: res_vld=1 res=%0d with no result pending (t=%0t)", r1, $time);
      end else begin
        e = exp1_q.pop_front();
        c = cyc1_q.pop_front();
        check("n1_res", 64'(r1), 64'(e));
        check("n1_latency", 64'(cyc), 64'(c + L1));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [95:0] bv [4];
  logic [17:0] be [4];
  logic [6:0]  pat;

  initial begin
    int j;
    int waitc;
    rst     = 1'b1;
    arg_vld = 1'b0;
    args    = 'x;
    a5_vld  = 1'b0;
    a5      = 'x;
    a1_vld  = 1'b0;
    a1      = 'x;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", 64'(res_vld), 64'd0);
    check("rst_res", 64'(res), 64'd0);
    check("rst_vld5", 64'(r5_vld), 64'd0);
    check("rst_res5", 64'(r5), 64'd0);
    check("rst_vld1", 64'(r1_vld), 64'd0);
    check("rst_res1", 64'(r1), 64'd0);
    #2 rst = 1'b0;
    idle(2);

    // Single vector: 6 + 5 + 4.
    send(v3(32'd36, 32'd25, 32'd16), 18'd15);
    idle(L + 3);

    // Boundary values: 4+1+0, three maxima, and mixed near-max roots
    // (65535 + 65534 + 46340).
    send(v3(32'd17, 32'd1, 32'd0), 18'd5);
    send(v3(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 18'd196605);
    send(v3(32'hFFFF_FFFF, 32'd4294836224, 32'h8000_0000), 18'd177409);
    idle(L + 2);

    // Streaming: k^2, (k+1)^2, (k+2)^2 -> 3k+3.
    for (int k = 0; k < 8; k++) begin
      send(v3(32'(k * k), 32'((k + 1) * (k + 1)), 32'((k + 2) * (k + 2))), 18'(3 * k + 3));
    end
    idle(L + 2);

    // Bubbles: valid pattern 1,0,0,1,1,0,1.
    bv[0] = v3(32'd100, 32'd49, 32'd4);            be[0] = 18'd19;     // 10+7+2
    bv[1] = v3(32'd99, 32'd48, 32'd3);             be[1] = 18'd16;     // 9+6+1
    bv[2] = v3(32'd1000000, 32'd65536, 32'd2);     be[2] = 18'd1257;   // 1000+256+1
    bv[3] = v3(32'd4294836225, 32'd3, 32'd8);      be[3] = 18'd65538;  // 65535+1+2
    pat = 7'b1001101;
    j = 0;
    for (int i = 6; i >= 0; i--) begin
      if (pat[i]) begin
        send(bv[j], be[j]);
        j++;
      end else begin
        idle(1);
      end
    end
    idle(L + 2);

    // Reset mid-flight: three vectors, asynchronous reset two cycles later.
    send(v3(32'd9, 32'd9, 32'd9), 18'd9);
    send(v3(32'd16, 32'd16, 32'd16), 18'd12);
    send(v3(32'd25, 32'd25, 32'd25), 18'd15);
    idle(2);
    #2 rst = 1'b1;
    #1;
    check("midrst_vld", 64'(res_vld), 64'd0);
    check("midrst_res", 64'(res), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    idle(L + 6);
    send(v3(32'd64, 32'd81, 32'd121), 18'd28);     // 8+9+11
    idle(L + 2);

    // Parameter sweep instances, issued back to back.
    @(posedge clk);
    #1;
    a5_vld = 1'b1;
    a5     = {5{16'hFFFF}};
    exp5_q.push_back(11'd1275);
    cyc5_q.push_back(cyc);
    a1_vld = 1'b1;
    a1     = 32'd100;
    exp1_q.push_back(16'd10);
    cyc1_q.push_back(cyc);
    @(posedge clk);
    #1;
    a5     = {16'd16, 16'd9, 16'd4, 16'd1, 16'd0};
    exp5_q.push_back(11'd10);
    cyc5_q.push_back(cyc);
    a1     = 32'd0;
    exp1_q.push_back(16'd0);
    cyc1_q.push_back(cyc);
    @(posedge clk);
    #1;
    a5_vld = 1'b0;
    a5     = 'x;
    a1     = 32'hFFFF_FFFF;
    exp1_q.push_back(16'd65535);
    cyc1_q.push_back(cyc);
    @(posedge clk);
    #1;
    a1     = 32'd99;
    exp1_q.push_back(16'd9);
    cyc1_q.push_back(cyc);
    @(posedge clk);
    #1;
    a1_vld = 1'b0;
    a1     = 'x;

    // Drain with a bounded wait.
    waitc = 0;
    while ((exp_q.size() + exp5_q.size() + exp1_q.size()) != 0 && waitc < 60) begin
      @(posedge clk);
      waitc++;
    end
    idle(3);
    total++;
    if ((exp_q.size() + exp5_q.size() + exp1_q.size()) != 0) begin
      bad++;
      $display("FAIL drain: %0d results still pending, expected 0",
               exp_q.size() + exp5_q.size() + exp1_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
